// File: rtl/uc_irq_pkg.sv
// Shared opcodes, ALU codes and control-word layout for the CPU control unit
// with its vectored interrupt controller.
package uc_irq_pkg;

  localparam logic [5:0] OP_JNZ  = 6'b000000;
  localparam logic [5:0] OP_JZ   = 6'b000001;
  localparam logic [5:0] OP_JMP  = 6'b000011;
  localparam logic [5:0] OP_RETI = 6'b111001;
  localparam logic [5:0] OP_CALL = 6'b111100;
  localparam logic [5:0] OP_RET  = 6'b111101;
  localparam logic [5:0] OP_EI   = 6'b111110;
  localparam logic [5:0] OP_DI   = 6'b111111;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic       push;
    logic       pop;
    logic       s_pop;
    logic       write_enable;
    logic       s_load;
    logic       we_es;
    logic       s_cargaes;
    logic       s_interrupcion;
    logic [2:0] op_alu;
  } ctl_t;

  function automatic ctl_t ctl_entry();
    ctl_t c;
    c = '0;
    c.push           = 1'b1;
    c.s_interrupcion = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/uc_irq_prio_enc.sv
// Lowest-set-index encoder: index 0 is the highest priority.
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the lowest set bit is the final assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/uc_irq.sv
// Single-cycle CPU control unit: opcode decode plus a prioritised, nestable,
// edge-triggered interrupt controller that overrides the decode on entry.
module uc_irq
  import uc_irq_pkg::*;
#(
  parameter  int N_IRQ      = 4,
  parameter  int NEST_DEPTH = 2,
  localparam int VEC_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             z,
  input  logic [N_IRQ-1:0] irq,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic             push,
  output logic             pop,
  output logic             s_pop,
  output logic             write_enable,
  output logic             s_load,
  output logic             we_es,
  output logic             s_cargaes,
  output logic             s_interrupcion,
  output logic [2:0]       op_alu,
  output logic [VEC_W-1:0] irq_vec,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             ie,
  output logic [N_IRQ-1:0] in_service
);

  localparam int NEST_W = $clog2(NEST_DEPTH + 1);

  logic [N_IRQ-1:0]  irq_q;
  logic [N_IRQ-1:0]  pend_q, pend_d;
  logic [N_IRQ-1:0]  isv_q, isv_d;
  logic [NEST_W-1:0] nest_q, nest_d;
  logic              ie_q, ie_d;

  logic              pend_v, isv_v;
  logic [VEC_W-1:0]  sel, isv_lo;
  logic              entry, reti_ok;
  logic [N_IRQ-1:0]  ack;
  ctl_t              dec, ctl;

  irq_prio_enc #(.N(N_IRQ), .W(VEC_W)) u_pend_enc (
    .req(pend_q), .valid(pend_v), .idx(sel)
  );

  irq_prio_enc #(.N(N_IRQ), .W(VEC_W)) u_isv_enc (
    .req(isv_q), .valid(isv_v), .idx(isv_lo)
  );

  assign entry   = ie_q && pend_v && (nest_q < NEST_W'(NEST_DEPTH)) &&
                   (!isv_v || (sel < isv_lo));
  assign reti_ok = (opcode == OP_RETI) && isv_v;
  assign ack     = entry ? (N_IRQ'(1) << sel) : '0;

  always_comb begin
    dec = '0;
    casez (opcode)
      OP_JMP: ;
      OP_JZ:  begin dec.wez = 1'b1; dec.s_inc = z;  end
      OP_JNZ: begin dec.wez = 1'b1; dec.s_inc = ~z; end
      6'b1010??: begin dec.s_inc = 1'b1; dec.s_inm = 1'b1; dec.we3 = 1'b1; end
      6'b0001??: begin
        dec.s_inc = 1'b1; dec.we3 = 1'b1; dec.wez = 1'b1; dec.op_alu = ALU_ADD;
      end
      6'b0010??: begin
        dec.s_inc = 1'b1; dec.we3 = 1'b1; dec.wez = 1'b1; dec.op_alu = ALU_SUB;
      end
      6'b0011??: begin dec.s_inc = 1'b1; dec.write_enable = 1'b1; end
      6'b0100??: begin dec.s_inc = 1'b1; dec.we3 = 1'b1; dec.s_load = 1'b1; end
      6'b0101??: begin dec.s_inc = 1'b1; dec.we3 = 1'b1; dec.s_cargaes = 1'b1; end
      6'b0110??: begin dec.s_inc = 1'b1; dec.we_es = 1'b1; end
      OP_CALL: dec.push = 1'b1;
      OP_RET:  begin dec.pop = 1'b1; dec.s_pop = 1'b1; end
      // A stray RETI with nothing in service must not touch the stack.
      OP_RETI: if (isv_v) begin dec.pop = 1'b1; dec.s_pop = 1'b1; end
      OP_EI, OP_DI: dec.s_inc = 1'b1;
      default: dec = '0;
    endcase
  end

  always_comb begin
    ctl = entry ? ctl_entry() : dec;
  end

  assign s_inc          = ctl.s_inc;
  assign s_inm          = ctl.s_inm;
  assign we3            = ctl.we3;
  assign wez            = ctl.wez;
  assign push           = ctl.push;
  assign pop            = ctl.pop;
  assign s_pop          = ctl.s_pop;
  assign write_enable   = ctl.write_enable;
  assign s_load         = ctl.s_load;
  assign we_es          = ctl.we_es;
  assign s_cargaes      = ctl.s_cargaes;
  assign s_interrupcion = ctl.s_interrupcion;
  assign op_alu         = ctl.op_alu;
  assign irq_vec        = entry ? sel : '0;
  assign irq_ack        = ack;
  assign ie             = ie_q;
  assign in_service     = isv_q;

  always_comb begin
    // A new rise on the line being acked keeps it pending.
    pend_d = (pend_q & ~ack) | (irq & ~irq_q);
    isv_d  = isv_q;
    nest_d = nest_q;
    ie_d   = ie_q;
    if (entry) begin
      isv_d  = isv_q | ack;
      nest_d = nest_q + NEST_W'(1);
    end else begin
      if (reti_ok) begin
        isv_d  = isv_q & ~(N_IRQ'(1) << isv_lo);
        nest_d = nest_q - NEST_W'(1);
      end
      if (opcode == OP_EI) ie_d = 1'b1;
      if (opcode == OP_DI) ie_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q  <= '1;
      pend_q <= '0;
      isv_q  <= '0;
      nest_q <= '0;
      ie_q   <= 1'b0;
    end else begin
      irq_q  <= irq;
      pend_q <= pend_d;
      isv_q  <= isv_d;
      nest_q <= nest_d;
      ie_q   <= ie_d;
    end
  end

endmodule

// File: tb/tb_uc_irq.sv
// Randomised self-checking bench for uc_irq against a behavioural interrupt model.
module tb_uc_irq;

  localparam int N  = 4;
  localparam int ND = 2;
  localparam int VW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [5:0]    opcode = 6'b000011;
  logic          z = 1'b0;
  logic [N-1:0]  irq = '0;
  logic          s_inc, s_inm, we3, wez, push, pop, s_pop, write_enable;
  logic          s_load, we_es, s_cargaes, s_interrupcion;
  logic [2:0]    op_alu;
  logic [VW-1:0] irq_vec;
  logic [N-1:0]  irq_ack;
  logic          ie;
  logic [N-1:0]  in_service;

  uc_irq #(.N_IRQ(N), .NEST_DEPTH(ND)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .irq(irq),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .push(push),
    .pop(pop), .s_pop(s_pop), .write_enable(write_enable), .s_load(s_load),
    .we_es(we_es), .s_cargaes(s_cargaes), .s_interrupcion(s_interrupcion),
    .op_alu(op_alu), .irq_vec(irq_vec), .irq_ack(irq_ack), .ie(ie),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: pending set, in-service set, depth, enable, last irq.
  bit           mp[N];
  bit           mis[N];
  int           mnest;
  bit           mie;
  logic [N-1:0] mprev;

  function automatic logic [14:0] word_of();
    return {s_inc, s_inm, we3, wez, push, pop, s_pop, write_enable, s_load,
            we_es, s_cargaes, s_interrupcion, op_alu};
  endfunction

  // Bit positions of the observed word above.
  localparam int SINC = 14, SINM = 13, WE3 = 12, WEZ = 11, PUSH = 10, POP = 9;
  localparam int SPOP = 8, WEN = 7, SLOAD = 6, WEES = 5, SCES = 4, SINT = 3;

  function automatic logic [14:0] decode_ref(input int op, input bit zz, input bit busy);
    logic [14:0] r;
    int grp;
    r = '0;
    grp = op / 4;
    if (op == 3) r = '0;
    else if (op == 1) begin r[WEZ] = 1; r[SINC] = zz; end
    else if (op == 0) begin r[WEZ] = 1; r[SINC] = !zz; end
    else if (op == 60) r[PUSH] = 1;
    else if (op == 61) begin r[POP] = 1; r[SPOP] = 1; end
    else if (op == 57) begin r[POP] = busy; r[SPOP] = busy; end
    else if (op == 62 || op == 63) r[SINC] = 1;
    else if (grp == 10) begin r[SINC] = 1; r[SINM] = 1; r[WE3] = 1; end
    else if (grp == 1) begin r[SINC] = 1; r[WE3] = 1; r[WEZ] = 1; r[2:0] = 3'd2; end
    else if (grp == 2) begin r[SINC] = 1; r[WE3] = 1; r[WEZ] = 1; r[2:0] = 3'd3; end
    else if (grp == 3) begin r[SINC] = 1; r[WEN] = 1; end
    else if (grp == 4) begin r[SINC] = 1; r[WE3] = 1; r[SLOAD] = 1; end
    else if (grp == 5) begin r[SINC] = 1; r[WE3] = 1; r[SCES] = 1; end
    else if (grp == 6) begin r[SINC] = 1; r[WEES] = 1; end
    return r;
  endfunction

  function automatic logic [N-1:0] pack_mis();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mis[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mp[i] = 0; mis[i] = 0; end
    mnest = 0;
    mie   = 0;
    mprev = '1;
  endtask

  // Entered and left at a falling edge; covers exactly one rising edge.
  task automatic cycle(input logic [5:0] op, input logic zz, input logic [N-1:0] ir);
    int s, l;
    bit ent;
    logic [14:0] ew;
    logic [N-1:0] eack;
    opcode = op; z = zz; irq = ir;
    #1;
    s = N; l = N;
    for (int i = N - 1; i >= 0; i--) begin
      if (mp[i]) s = i;
      if (mis[i]) l = i;
    end
    ent  = mie && (s < N) && (mnest < ND) && (s < l);
    eack = '0;
    if (ent) begin
      ew = '0; ew[PUSH] = 1; ew[SINT] = 1;
      eack[s] = 1'b1;
    end else begin
      ew = decode_ref(int'(op), zz, l < N);
    end
    chk("ctl_word", 32'(word_of()), 32'(ew));
    chk("vec_ack", {irq_vec, irq_ack}, {(ent ? VW'(s) : VW'(0)), eack});
    chk("ie_isv", {ie, in_service}, {mie, pack_mis()});
    if (ent) begin
      mp[s] = 0; mis[s] = 1; mnest++;
    end else begin
      if (int'(op) == 57 && l < N) begin mis[l] = 0; mnest--; end
      if (int'(op) == 62) mie = 1;
      if (int'(op) == 63) mie = 0;
    end
    for (int i = 0; i < N; i++) if (ir[i] && !mprev[i]) mp[i] = 1;
    mprev = ir;
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, holds irq, releases at a falling edge.
  task automatic pulse_reset(input logic [N-1:0] hold);
    irq = hold;
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_ie_isv", {ie, in_service}, {1'b0, {N{1'b0}}});
    chk("rst_ack", irq_ack, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  localparam logic [5:0] JMP = 6'b000011, EI = 6'b111110, DI = 6'b111111, RETI = 6'b111001;

  initial begin
    logic [5:0]   rop;
    logic [N-1:0] rirq;
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Decode straight after reset, checked against hard constants.
    opcode = 6'b000100; z = 1'b0; #1;
    chk("add_word", 32'(word_of()), 32'h5802);
    opcode = 6'b000001; z = 1'b1; #1;
    chk("jz_word", 32'(word_of()), 32'h4800);
    @(negedge clk);
    mprev = irq;

    // Request while disabled, then EI.
    cycle(JMP, 0, 4'b0100);
    cycle(EI,  0, 4'b0100);
    chk("ei_pending_entry", {s_interrupcion, push, irq_ack, 2'(irq_vec)}, {2'b11, 4'b0100, 2'd2});
    cycle(JMP, 0, 4'b0100);
    cycle(RETI, 0, 4'b0000);

    // Simultaneous rises, priority blocking, RETI releases lower priority.
    cycle(JMP, 0, 4'b1010);
    cycle(JMP, 0, 4'b1010);
    cycle(JMP, 0, 4'b1010);
    cycle(RETI, 0, 4'b1010);
    cycle(JMP, 0, 4'b1010);
    cycle(RETI, 0, 4'b0000);

    // Nesting to full depth.
    cycle(JMP, 0, 4'b0100);
    cycle(JMP, 0, 4'b0100);
    cycle(JMP, 0, 4'b0101);
    cycle(JMP, 0, 4'b0101);
    cycle(JMP, 0, 4'b0111);
    cycle(JMP, 0, 4'b0111);
    cycle(RETI, 0, 4'b0111);
    cycle(JMP, 0, 4'b0111);
    cycle(RETI, 0, 4'b0000);
    cycle(RETI, 0, 4'b0000);

    // Stray RETI, then DI masking a pending request until EI.
    cycle(RETI, 0, 4'b0000);
    cycle(DI,   0, 4'b1000);
    cycle(JMP,  0, 4'b1000);
    cycle(EI,   0, 4'b1000);
    cycle(JMP,  1, 4'b1000);
    cycle(RETI, 0, 4'b0000);

    // Reset mid-service with lines held high across release.
    cycle(JMP, 0, 4'b0001);
    cycle(JMP, 0, 4'b0001);
    pulse_reset(4'b1111);
    cycle(EI,  0, 4'b1111);
    cycle(JMP, 0, 4'b1111);
    cycle(JMP, 0, 4'b1111);

    // Random traffic biased toward interrupt-relevant opcodes.
    rirq = 4'b1111;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0:       rop = EI;
        1:       rop = DI;
        2, 3:    rop = RETI;
        4:       rop = JMP;
        default: rop = 6'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 2) == 0) rirq[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 499) == 0) pulse_reset(rirq);
      else cycle(rop, 1'($urandom_range(0, 1)), rirq);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
